alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It keeps the existing 4-bit operation encoding and adds registered outputs, a start/busy/done handshake, XOR/NOR, and signed/unsigned compare. Iterative unsigned multiply and divide run through an internal FSM. It sits in the execute stage, and the control unit stalls the PC while busy=1.

---
 rtl/alu_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq -- multi-cycle execute-stage ALU with a start/busy/done handshake.
//
// Single-cycle ops (ADD, SUB, AND, OR, XOR, NOR, SLTU, SLT and divide by zero)
// complete one cycle after start. MULU (shift-add) and DIVU/REMU (restoring
// division) iterate one bit per cycle and complete WIDTH+1 cycles after start.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (also aborts an operation in flight)
//   start  one-cycle request, only sampled while idle
//   op1    operand A, captured when start is accepted
//   op2    operand B, captured when start is accepted
//   sel    4-bit operation code, captured when start is accepted
//   busy   high while a multi-cycle operation is in progress
//   done   one-cycle pulse; R_OP, R_HI and the flags are valid
//   R_OP   result low word / quotient (remainder for REMU)
//   R_HI   product high word / remainder (quotient for REMU); 0 otherwise
//   ZF     R_OP == 0
//   OF     signed overflow for ADD/SUB
//   DZ     divide by zero for DIVU/REMU
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter bit MUL_DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R_OP,
    output logic [WIDTH-1:0] R_HI,
    output logic             ZF,
    output logic             OF,
    output logic             DZ
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            done_reg, done_next;
    logic [WIDTH-1:0] r_op_reg, r_hi_reg;
    logic            zf_reg, of_reg, dz_reg;

    logic            load_out;
    logic [WIDTH-1:0] out_lo_next, out_hi_next;
    logic            of_next, dz_next;
    logic            start_mul, start_div, step_en;
    logic [WIDTH-1:0] fin_lo, fin_hi;

    // ---------------- single-cycle datapath ----------------
    logic [3:0]       op_eff;
    logic [WIDTH-1:0] add_res, sub_res, alu_lo, alu_hi;
    logic             alu_of, alu_dz;

    assign add_res = op1 + op2;
    assign sub_res = op1 - op2;

    // Without the iterative unit, the multiply/divide codes fall back to ADD.
    always_comb begin
        op_eff = sel;
        if (!MUL_DIV_EN && (sel == OP_MULU || sel == OP_DIVU || sel == OP_REMU))
            op_eff = OP_ADD;
    end

    always_comb begin
        alu_lo = add_res;
        alu_hi = '0;
        alu_of = 1'b0;
        alu_dz = 1'b0;
        case (op_eff)
            OP_SUB: begin
                alu_lo = sub_res;
                // Overflow test with B inverted: operands of differing sign.
                alu_of = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_res[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND:  alu_lo = op1 & op2;
            OP_OR:   alu_lo = op1 | op2;
            OP_XOR:  alu_lo = op1 ^ op2;
            OP_NOR:  alu_lo = ~(op1 | op2);
            OP_SLTU: begin
                alu_lo    = '0;
                alu_lo[0] = (op1 < op2);
            end
            OP_SLT: begin
                alu_lo    = '0;
                alu_lo[0] = ($signed(op1) < $signed(op2));
            end
            // Only reached as single-cycle ops when the divisor is zero.
            OP_DIVU: begin
                alu_lo = '1;
                alu_hi = op1;
                alu_dz = 1'b1;
            end
            OP_REMU: begin
                alu_lo = op1;
                alu_hi = '1;
                alu_dz = 1'b1;
            end
            default: begin
                alu_lo = add_res;
                alu_of = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_res[WIDTH-1] != op1[WIDTH-1]);
            end
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        done_next   = 1'b0;
        load_out    = 1'b0;
        out_lo_next = alu_lo;
        out_hi_next = alu_hi;
        of_next     = alu_of;
        dz_next     = alu_dz;
        start_mul   = 1'b0;
        start_div   = 1'b0;
        step_en     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (MUL_DIV_EN && op_eff == OP_MULU) begin
                        start_mul  = 1'b1;
                        cnt_next   = CW'(WIDTH);
                        state_next = S_MUL;
                    end else if (MUL_DIV_EN && (op_eff == OP_DIVU || op_eff == OP_REMU)
                                 && op2 != '0) begin
                        start_div  = 1'b1;
                        cnt_next   = CW'(WIDTH);
                        state_next = S_DIV;
                    end else begin
                        load_out  = 1'b1;
                        done_next = 1'b1;
                    end
                end
            end
            // WIDTH-1 steps are registered here; the last step is folded
            // into FIN so the result lands exactly WIDTH+1 cycles after start.
            S_MUL, S_DIV: begin
                step_en  = 1'b1;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CW'(2))
                    state_next = S_FIN;
            end
            S_FIN: begin
                load_out    = 1'b1;
                done_next   = 1'b1;
                out_lo_next = fin_lo;
                out_hi_next = fin_hi;
                of_next     = 1'b0;
                dz_next     = 1'b0;
                cnt_next    = '0;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            r_op_reg  <= '0;
            r_hi_reg  <= '0;
            zf_reg    <= 1'b0;
            of_reg    <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            if (load_out) begin
                r_op_reg <= out_lo_next;
                r_hi_reg <= out_hi_next;
                zf_reg   <= (out_lo_next == '0);
                of_reg   <= of_next;
                dz_reg   <= dz_next;
            end
        end
    end

    // ---------------- iterative multiply / divide unit ----------------
    generate
        if (MUL_DIV_EN) begin : g_md
            // hi/lo form one 2*WIDTH shift register: product high:low for
            // multiply, remainder:dividend(->quotient) for divide.
            logic [WIDTH-1:0] hi_reg, lo_reg, dvs_reg;
            logic             div_reg, rem_reg;
            logic [WIDTH:0]   mul_sum, div_sh;
            logic             div_ge;
            logic [WIDTH-1:0] nxt_hi, nxt_lo;

            always_comb begin
                mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, dvs_reg} : '0);
                div_sh  = {hi_reg, lo_reg[WIDTH-1]};
                div_ge  = (div_sh >= {1'b0, dvs_reg});
                if (div_reg) begin
                    // The true difference is below the divisor, so W bits suffice.
                    nxt_hi = div_ge ? (div_sh[WIDTH-1:0] - dvs_reg) : div_sh[WIDTH-1:0];
                    nxt_lo = {lo_reg[WIDTH-2:0], div_ge};
                end else begin
                    nxt_hi = mul_sum[WIDTH:1];
                    nxt_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hi_reg  <= '0;
                    lo_reg  <= '0;
                    dvs_reg <= '0;
                    div_reg <= 1'b0;
                    rem_reg <= 1'b0;
                end else if (start_mul || start_div) begin
                    hi_reg  <= '0;
                    lo_reg  <= op1;
                    dvs_reg <= op2;
                    div_reg <= start_div;
                    rem_reg <= start_div && (sel == OP_REMU);
                end else if (step_en) begin
                    hi_reg <= nxt_hi;
                    lo_reg <= nxt_lo;
                end
            end

            assign fin_lo = rem_reg ? nxt_hi : nxt_lo;
            assign fin_hi = rem_reg ? nxt_lo : nxt_hi;
        end else begin : g_no_md
            assign fin_lo = '0;
            assign fin_hi = '0;
        end
    endgenerate

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign R_OP = r_op_reg;
    assign R_HI = r_hi_reg;
    assign ZF   = zf_reg;
    assign OF   = of_reg;
    assign DZ   = dz_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq: a WIDTH=32 instance with multiply/divide
// and a second instance with MUL_DIV_EN=0 sharing the same stimulus.
module tb_alu_seq;
    localparam int W = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op1, op2;
    logic [3:0]   sel;

    logic         busy, done, zf, of, dz;
    logic [W-1:0] r_op, r_hi;
    logic         busy_n, done_n, zf_n, of_n, dz_n;
    logic [W-1:0] r_op_n, r_hi_n;

    int checks = 0;
    int errors = 0;
    int lat;
    int done_seen;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_DIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2), .sel(sel),
        .busy(busy), .done(done), .R_OP(r_op), .R_HI(r_hi),
        .ZF(zf), .OF(of), .DZ(dz)
    );

    alu_seq #(.WIDTH(W), .MUL_DIV_EN(1'b0)) dut_nomd (
        .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2), .sel(sel),
        .busy(busy_n), .done(done_n), .R_OP(r_op_n), .R_HI(r_hi_n),
        .ZF(zf_n), .OF(of_n), .DZ(dz_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat = cycles from start edge.
    task automatic run_op(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int l);
        sel   = s;
        op1   = a;
        op2   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        l = 1;
        while (done !== 1'b1 && l < 60) begin
            tick();
            l++;
        end
        chk("done_within_bound", {63'd0, done}, 64'd1);
        $display("op sel=%b op1=%h op2=%h -> R_OP=%h R_HI=%h ZF=%b OF=%b DZ=%b lat=%0d",
                 s, a, b, r_op, r_hi, zf, of, dz, l);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op1   = '0;
        op2   = '0;
        sel   = OP_ADD;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_r_op", r_op, 0);
        chk("reset_r_hi", r_hi, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_flags", {zf, of, dz}, 0);

        // ADD overflow, 1-cycle latency
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat);
        chk("add_lat", lat, 1);
        chk("add_r_op", r_op, 32'h8000_0000);
        chk("add_of", of, 1);
        chk("add_zf", zf, 0);
        chk("add_r_hi", r_hi, 0);
        tick();
        chk("add_done_pulse_ends", done, 0);
        chk("add_r_op_held", r_op, 32'h8000_0000);

        run_op(OP_SUB, 32'd5, 32'd5, lat);
        chk("sub_r_op", r_op, 0);
        chk("sub_zf", zf, 1);
        chk("sub_of", of, 0);

        run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, lat);
        chk("sltu_r_op", r_op, 0);
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat);
        chk("slt_r_op", r_op, 1);
        run_op(4'b1111, 32'd3, 32'd4, lat);
        chk("undef_add_r_op", r_op, 7);

        // MULU with exact cycle accounting; a start at cycle 10 must be ignored
        sel   = OP_MULU;
        op1   = 32'hFFFF_FFFF;
        op2   = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            chk($sformatf("mul_busy_c%0d", n), busy, 1);
            chk($sformatf("mul_nodone_c%0d", n), done, 0);
            if (n == 10) begin
                start = 1'b1;
                sel   = OP_ADD;
                op1   = 32'd1;
                op2   = 32'd1;
            end
            tick();
            start = 1'b0;
        end
        chk("mul_done_c33", done, 1);
        chk("mul_busy_c33", busy, 0);
        chk("mul_r_hi", r_hi, 32'hFFFF_FFFE);
        chk("mul_r_op", r_op, 32'h0000_0001);
        chk("mul_flags", {zf, of, dz}, 0);
        $display("op sel=%b MULU ffffffff*ffffffff -> R_OP=%h R_HI=%h", OP_MULU, r_op, r_hi);
        tick();
        chk("mul_done_pulse_ends", done, 0);

        run_op(OP_DIVU, 32'd100, 32'd7, lat);
        chk("divu_lat", lat, 33);
        chk("divu_r_op", r_op, 14);
        chk("divu_r_hi", r_hi, 2);
        chk("divu_dz", dz, 0);
        run_op(OP_REMU, 32'd100, 32'd7, lat);
        chk("remu_r_op", r_op, 2);
        chk("remu_r_hi", r_hi, 14);
        run_op(OP_DIVU, 32'd9, 32'd0, lat);
        chk("divz_lat", lat, 1);
        chk("divz_r_op", r_op, 32'hFFFF_FFFF);
        chk("divz_r_hi", r_hi, 9);
        chk("divz_dz", dz, 1);
        run_op(OP_REMU, 32'd9, 32'd0, lat);
        chk("remz_r_op", r_op, 9);
        chk("remz_r_hi", r_hi, 32'hFFFF_FFFF);
        run_op(OP_ADD, 32'd3, 32'd4, lat);
        chk("add_clears_dz", dz, 0);
        chk("add_clears_r_hi", r_hi, 0);

        // Back-to-back single-cycle ops
        op1   = 32'h0000_F0F0;
        op2   = 32'h0000_0FF0;
        start = 1'b1;
        sel   = OP_AND;
        tick();
        chk("b2b_and_done", done, 1);
        chk("b2b_and_r_op", r_op, 32'h0000_00F0);
        sel = OP_OR;
        tick();
        chk("b2b_or_done", done, 1);
        chk("b2b_or_r_op", r_op, 32'h0000_FFF0);
        sel = OP_XOR;
        tick();
        chk("b2b_xor_done", done, 1);
        chk("b2b_xor_r_op", r_op, 32'h0000_FF00);
        sel = OP_NOR;
        tick();
        start = 1'b0;
        chk("b2b_nor_done", done, 1);
        chk("b2b_nor_r_op", r_op, 32'hFFFF_000F);
        $display("b2b AND/OR/XOR/NOR last R_OP=%h", r_op);
        tick();
        chk("b2b_done_ends", done, 0);

        // Reset in the middle of a MULU aborts it without a done pulse
        sel   = OP_MULU;
        op1   = 32'd3;
        op2   = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("abort_r_op", r_op, 0);
        chk("abort_r_hi", r_hi, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_flags", {zf, of, dz}, 0);
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        chk("abort_no_done", done_seen, 0);
        $display("reset during MULU: done pulses seen=%0d", done_seen);
        run_op(OP_ADD, 32'd3, 32'd4, lat);
        chk("post_abort_add_lat", lat, 1);
        chk("post_abort_add_r_op", r_op, 7);
        run_op(OP_MULU, 32'd3, 32'd4, lat);
        chk("post_abort_mul_lat", lat, 33);
        chk("post_abort_mul_r_op", r_op, 12);
        chk("post_abort_mul_r_hi", r_hi, 0);

        // MUL_DIV_EN=0 instance: MULU executes as a 1-cycle ADD
        sel   = OP_MULU;
        op1   = 32'd3;
        op2   = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("nomd_done", done_n, 1);
        chk("nomd_busy", busy_n, 0);
        chk("nomd_r_op", r_op_n, 7);
        chk("nomd_r_hi", r_hi_n, 0);
        $display("nomd MULU 3*4 -> R_OP=%h", r_op_n);
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        chk("md_mul_lat", lat, 33);
        chk("md_mul_r_op", r_op, 12);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
